// File: rtl/pipe_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the stall controller (slave).
// halt_req is a level: the requester holds it until halted rises. The controller
// accepts it only in a RUN cycle with dmem_stall low; there is no separate ready.
interface pipe_stall_ctrl_if;
   logic        halt_req;
   logic        ld_use_haz;
   logic        br_taken;
   logic        imem_stall;
   logic        dmem_stall;
   logic        en_pc;
   logic        en_ifid;
   logic        en_idex;
   logic        en_exmem;
   logic        en_memwb;
   logic        flush_ifid;
   logic        flush_idex;
   logic [2:0]  state;
   logic        halted;
   logic        err;
   logic [15:0] stall_cnt;

   modport master (
      output halt_req, ld_use_haz, br_taken, imem_stall, dmem_stall,
      input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
      input  flush_ifid, flush_idex, state, halted, err, stall_cnt
   );

   modport slave (
      input  halt_req, ld_use_haz, br_taken, imem_stall, dmem_stall,
      output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
      output flush_ifid, flush_idex, state, halted, err, stall_cnt
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush/halt controller with dmem-stall timeout and drain-before-halt.
// Define STALL_PERF_EN to add the saturating stall-cycle counter on stall_cnt.
module pipe_stall_ctrl #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned DRAIN   = 3
) (
   input  logic             clk,
   input  logic             rst,
   pipe_stall_ctrl_if.slave bus
);
   localparam int unsigned TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_RUN    = 3'd0,
      S_MSTALL = 3'd1,
      S_DRAIN  = 3'd2,
      S_HALT   = 3'd3,
      S_ERR    = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    drain_q, drain_d;

   logic run_en_pc, run_en_ifid, run_fl_ifid, run_fl_idex;
   logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
   logic fl_ifid, fl_idex, halted, err;

   // RUN-state hazard resolution with dmem_stall already known to be low.
   always_comb begin
      run_en_pc   = 1'b1;
      run_en_ifid = 1'b1;
      run_fl_ifid = 1'b0;
      run_fl_idex = 1'b0;
      if (bus.br_taken) begin
         run_fl_ifid = 1'b1;
         run_fl_idex = 1'b1;
      end else if (bus.ld_use_haz) begin
         run_en_pc   = 1'b0;
         run_en_ifid = 1'b0;
         run_fl_idex = 1'b1;
      end else if (bus.imem_stall) begin
         run_en_pc   = 1'b0;
         run_fl_ifid = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RUN;
         timer_q <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      drain_d  = drain_q;
      en_pc    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
      fl_ifid  = 1'b0;
      fl_idex  = 1'b0;
      halted   = 1'b0;
      err      = 1'b0;
      case (state_q)
         S_RUN: begin
            if (bus.dmem_stall) begin
               state_d = S_MSTALL;
               timer_d = TW'(1);
            end else begin
               en_pc    = run_en_pc;
               en_ifid  = run_en_ifid;
               en_idex  = 1'b1;
               en_exmem = 1'b1;
               en_memwb = 1'b1;
               fl_ifid  = run_fl_ifid;
               fl_idex  = run_fl_idex;
               if (bus.halt_req) begin
                  state_d = S_DRAIN;
                  drain_d = '0;
               end
            end
         end
         S_MSTALL: begin
            // halt_req is not looked at here; the requester keeps it asserted.
            if (!bus.dmem_stall) begin
               en_pc    = run_en_pc;
               en_ifid  = run_en_ifid;
               en_idex  = 1'b1;
               en_exmem = 1'b1;
               en_memwb = 1'b1;
               fl_ifid  = run_fl_ifid;
               fl_idex  = run_fl_idex;
               state_d  = S_RUN;
               timer_d  = '0;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d = S_ERR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_DRAIN: begin
            if (!bus.dmem_stall) begin
               en_ifid  = 1'b1;
               en_idex  = 1'b1;
               en_exmem = 1'b1;
               en_memwb = 1'b1;
               fl_ifid  = 1'b1;
               if (drain_q == 4'(DRAIN - 1)) begin
                  state_d = S_HALT;
               end else begin
                  drain_d = drain_q + 4'd1;
               end
            end
         end
         S_HALT: halted = 1'b1;
         S_ERR:  err    = 1'b1;
         default: state_d = S_ERR;
      endcase
      // A latch receiving both flush and enable clears; flush wins inside the latch.
      if (rst) begin
         en_pc    = 1'b0;
         en_ifid  = 1'b0;
         en_idex  = 1'b0;
         en_exmem = 1'b0;
         en_memwb = 1'b0;
         fl_ifid  = 1'b0;
         fl_idex  = 1'b0;
         halted   = 1'b0;
         err      = 1'b0;
      end
   end

   assign bus.en_pc      = en_pc;
   assign bus.en_ifid    = en_ifid;
   assign bus.en_idex    = en_idex;
   assign bus.en_exmem   = en_exmem;
   assign bus.en_memwb   = en_memwb;
   assign bus.flush_ifid = fl_ifid;
   assign bus.flush_idex = fl_idex;
   assign bus.state      = state_q;
   assign bus.halted     = halted;
   assign bus.err        = err;

`ifdef STALL_PERF_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!en_pc && (state_q == S_RUN || state_q == S_MSTALL || state_q == S_DRAIN)
          && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign bus.stall_cnt = cnt_q;
`else
   assign bus.stall_cnt = 16'd0;
`endif
endmodule
